stream_demux: RTL and testbench

STREAM_DEMUX -- requirements
Module: stream_demux

---
 rtl/stream_demux_if.sv | 29 ++
 rtl/stream_demux.sv | 91 +++++++++
 tb/tb_stream_demux.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/stream_demux_if.sv
// Stream demux bus: one upstream valid/ready port and N
// downstream channels sharing data/last with per-channel valid/ready.
interface stream_demux_if #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 3
);
  localparam int N = 2**SEL_W;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [SEL_W-1:0]  in_sel;
  logic              in_bcast;
  logic              in_last;
  logic [N-1:0]      out_valid;
  logic [N-1:0]      out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport slave (
    input  in_valid, in_data, in_sel, in_bcast, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_data, in_sel, in_bcast, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/stream_demux.sv
// Packet demux: routes each packet to one channel or all,
// holding one beat until every target channel has taken it.
module stream_demux #(
  parameter int DATA_W = 8,
  parameter int SEL_W  = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  stream_demux_if.slave bus,
  output logic [15:0] pkt_cnt
);
  localparam int N = 2**SEL_W;

  typedef enum logic {S_IDLE, S_PKT} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [N-1:0]      r_route;
  logic [N-1:0]      r_pend;
  logic [DATA_W-1:0] r_data;
  logic              r_last;
  logic [15:0]       r_cnt;

  logic [N-1:0]      w_left;
  logic [N-1:0]      w_route;
  logic [N-1:0]      w_pend_nxt;
  logic              w_ready;
  logic              w_acc;
  logic              w_done;

  // Bits still pending after this cycle's handshakes
  assign w_left  = r_pend & ~bus.out_ready;
  assign w_ready = (w_left == '0);
  assign w_acc   = bus.in_valid & w_ready;
  assign w_done  = (r_pend != '0) & (w_left == '0) & r_last;

  assign bus.in_ready  = w_ready;
  assign bus.out_valid = r_pend;
  assign bus.out_data  = r_data;
  assign bus.out_last  = r_last;
  assign pkt_cnt       = r_cnt;

  always_comb begin
    w_route = r_route;
    if (r_state == S_IDLE) begin
      w_route = bus.in_bcast ? '1 : (N'(1) << bus.in_sel);
    end
    w_pend_nxt = w_acc ? w_route : w_left;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_acc) begin
      unique case (r_state)
        S_IDLE: if (!bus.in_last) w_state_nxt = S_PKT;
        S_PKT:  if (bus.in_last)  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_route <= '0;
      r_pend  <= '0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      if (w_acc && r_state == S_IDLE) begin
        r_route <= w_route;
      end
      if (w_acc) begin
        r_data <= bus.in_data;
        r_last <= bus.in_last;
      end
      if (w_done && r_cnt != 16'hFFFF) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux: unicast, route lock, broadcast,
// backpressure, mid-packet reset and counter saturation.
module tb_stream_demux;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] pkt_cnt;
  int          total = 0;
  int          bad = 0;

  stream_demux_if #(.DATA_W(8), .SEL_W(3)) bus ();

  stream_demux #(.DATA_W(8), .SEL_W(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .pkt_cnt (pkt_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d,
                       input logic [2:0] s, input logic b,
                       input logic l);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_sel   = s;
    bus.in_bcast = b;
    bus.in_last  = l;
    #1;
  endtask

  initial begin
    bus.out_ready = 8'h00;
    drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    #2;
    chk("rst_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_ready", 32'(bus.in_ready), 32'h1);
    chk("rst_data",  32'(bus.out_data), 32'h0);
    chk("rst_last",  32'(bus.out_last), 32'h0);
    chk("rst_cnt",   32'(pkt_cnt), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // unicast, sel=5
    bus.out_ready = 8'hFF;
    drive(1'b1, 8'h11, 3'd5, 1'b0, 1'b0);
    chk("uc_rdy0", 32'(bus.in_ready), 32'h1);
    tick();
    drive(1'b1, 8'h22, 3'd5, 1'b0, 1'b0);
    chk("uc_v1", 32'(bus.out_valid), 32'h20);
    chk("uc_d1", 32'(bus.out_data), 32'h11);
    chk("uc_rdy1", 32'(bus.in_ready), 32'h1);
    tick();
    drive(1'b1, 8'h33, 3'd5, 1'b0, 1'b1);
    chk("uc_v2", 32'(bus.out_valid), 32'h20);
    chk("uc_d2", 32'(bus.out_data), 32'h22);
    chk("uc_rdy2", 32'(bus.in_ready), 32'h1);
    tick();
    drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    chk("uc_v3", 32'(bus.out_valid), 32'h20);
    chk("uc_d3", 32'(bus.out_data), 32'h33);
    chk("uc_l3", 32'(bus.out_last), 32'h1);
    chk("uc_cnt_pre", 32'(pkt_cnt), 32'h0);
    tick();
    chk("uc_v4", 32'(bus.out_valid), 32'h0);
    chk("uc_cnt", 32'(pkt_cnt), 32'h1);

    // route lock: opened on ch2, later beats say sel=6
    drive(1'b1, 8'h40, 3'd2, 1'b0, 1'b0);
    tick();
    drive(1'b1, 8'h41, 3'd6, 1'b0, 1'b0);
    chk("lk_v1", 32'(bus.out_valid), 32'h04);
    tick();
    drive(1'b1, 8'h42, 3'd6, 1'b1, 1'b1);
    chk("lk_v2", 32'(bus.out_valid), 32'h04);
    chk("lk_d2", 32'(bus.out_data), 32'h41);
    tick();
    drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    chk("lk_v3", 32'(bus.out_valid), 32'h04);
    chk("lk_d3", 32'(bus.out_data), 32'h42);
    tick();
    chk("lk_v4", 32'(bus.out_valid), 32'h0);
    chk("lk_cnt", 32'(pkt_cnt), 32'h2);

    // broadcast with split acceptance
    bus.out_ready = 8'h00;
    drive(1'b1, 8'hA5, 3'd1, 1'b1, 1'b1);
    tick();
    drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    bus.out_ready = 8'h0F;
    #1;
    chk("bc_v1", 32'(bus.out_valid), 32'hFF);
    chk("bc_rdy1", 32'(bus.in_ready), 32'h0);
    tick();
    bus.out_ready = 8'h00;
    #1;
    chk("bc_v2", 32'(bus.out_valid), 32'hF0);
    chk("bc_rdy2", 32'(bus.in_ready), 32'h0);
    chk("bc_d2", 32'(bus.out_data), 32'hA5);
    chk("bc_cnt2", 32'(pkt_cnt), 32'h2);
    tick();
    bus.out_ready = 8'hF0;
    #1;
    chk("bc_v3", 32'(bus.out_valid), 32'hF0);
    chk("bc_rdy3", 32'(bus.in_ready), 32'h1);
    chk("bc_cnt3", 32'(pkt_cnt), 32'h2);
    tick();
    chk("bc_v4", 32'(bus.out_valid), 32'h0);
    chk("bc_cnt4", 32'(pkt_cnt), 32'h3);

    // backpressure on ch0
    bus.out_ready = 8'h00;
    drive(1'b1, 8'h5A, 3'd0, 1'b0, 1'b1);
    tick();
    drive(1'b1, 8'h5B, 3'd0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("bp_v", 32'(bus.out_valid), 32'h01);
      chk("bp_d", 32'(bus.out_data), 32'h5A);
      chk("bp_l", 32'(bus.out_last), 32'h1);
      chk("bp_rdy", 32'(bus.in_ready), 32'h0);
      tick();
    end
    bus.out_ready = 8'h01;
    #1;
    chk("bp_rdy_go", 32'(bus.in_ready), 32'h1);
    tick();
    drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    chk("bp_v_nb", 32'(bus.out_valid), 32'h01);
    chk("bp_d_nb", 32'(bus.out_data), 32'h5B);
    chk("bp_cnt1", 32'(pkt_cnt), 32'h4);
    tick();
    chk("bp_v_end", 32'(bus.out_valid), 32'h0);
    chk("bp_cnt2", 32'(pkt_cnt), 32'h5);

    // reset during beat 2 of a 4-beat packet on ch3
    bus.out_ready = 8'h00;
    drive(1'b1, 8'h70, 3'd3, 1'b0, 1'b0);
    tick();
    drive(1'b1, 8'h71, 3'd3, 1'b0, 1'b0);
    chk("mr_v_pre", 32'(bus.out_valid), 32'h08);
    rst_n = 1'b0;
    #1;
    chk("mr_v", 32'(bus.out_valid), 32'h0);
    chk("mr_rdy", 32'(bus.in_ready), 32'h1);
    chk("mr_d", 32'(bus.out_data), 32'h0);
    chk("mr_l", 32'(bus.out_last), 32'h0);
    chk("mr_cnt", 32'(pkt_cnt), 32'h0);
    drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    bus.out_ready = 8'hFF;
    drive(1'b1, 8'h80, 3'd1, 1'b0, 1'b1);
    tick();
    drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    chk("mr_v_new", 32'(bus.out_valid), 32'h02);
    chk("mr_d_new", 32'(bus.out_data), 32'h80);
    tick();
    chk("mr_cnt_new", 32'(pkt_cnt), 32'h1);

    // saturation: pkt_cnt=1 here, 65533 more reach 16'hFFFE
    drive(1'b1, 8'h01, 3'd4, 1'b0, 1'b1);
    for (int i = 0; i < 65533; i++) tick();
    drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    tick();
    chk("sat_fffe", 32'(pkt_cnt), 32'hFFFE);
    drive(1'b1, 8'h02, 3'd4, 1'b0, 1'b1);
    tick();
    drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    tick();
    chk("sat_ffff", 32'(pkt_cnt), 32'hFFFF);
    drive(1'b1, 8'h03, 3'd4, 1'b0, 1'b1);
    tick();
    tick();
    drive(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
    tick();
    chk("sat_hold", 32'(pkt_cnt), 32'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
